// File: rtl/seq_divider_pkg.sv
// Shared constants and state encoding for the iterative restoring divider.
// Imported by seq_divider and by anything that decodes its handshake.
package seq_divider_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE    = 2'b00,
    DIV_DIVZERO = 2'b01,
    DIV_BUSY    = 2'b10,
    DIV_DONE    = 2'b11
  } div_state_e;

  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

endpackage

// File: rtl/seq_divider.sv
// Radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle,
// result {remainder, quotient} presented with a one-cycle ready pulse.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam int CNT_W = $clog2(WIDTH);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rem_q, quo_q, div_q, dvd_q;
  logic             neg_q_q, neg_r_q;

  logic             accept, last, take;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   partial, trial;
  logic [WIDTH-1:0] rem_nxt, quo_nxt;

  function automatic logic [WIDTH-1:0] negate_if(input logic en, input logic [WIDTH-1:0] v);
    return en ? ('0 - v) : v;
  endfunction

  assign accept = (state_q == DIV_IDLE) && (start_i == DIV_START) && !annul_i;
  assign last   = (cnt_q == CNT_W'(WIDTH - 1));
  assign a_neg  = signed_div_i && opdata1_i[WIDTH-1];
  assign b_neg  = signed_div_i && opdata2_i[WIDTH-1];
  assign a_abs  = negate_if(a_neg, opdata1_i);
  assign b_abs  = negate_if(b_neg, opdata2_i);

  // A set partial MSB already exceeds any WIDTH-bit divisor, so the trial
  // only needs WIDTH+1 bits.
  assign partial = {rem_q, quo_q[WIDTH-1]};
  assign trial   = partial - {1'b0, div_q};
  assign take    = partial[WIDTH] | ~trial[WIDTH];
  assign rem_nxt = take ? trial[WIDTH-1:0] : partial[WIDTH-1:0];
  assign quo_nxt = {quo_q[WIDTH-2:0], take};

  assign ready_o = (state_q == DIV_DONE) ? DIV_RESULT_READY : DIV_RESULT_NOT_READY;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= DIV_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DIV_IDLE:    if (accept) state_d = (opdata2_i == '0) ? DIV_DIVZERO : DIV_BUSY;
      DIV_DIVZERO: state_d = annul_i ? DIV_IDLE : DIV_DONE;
      DIV_BUSY: begin
        if (annul_i)   state_d = DIV_IDLE;
        else if (last) state_d = DIV_DONE;
      end
      DIV_DONE:    state_d = DIV_IDLE;
      default:     state_d = DIV_IDLE;
    endcase
  end

  // Operand latch, shift/subtract iteration and result capture.
  // The result is registered on the edge entering DONE so it is valid with ready_o.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      div_q    <= '0;
      dvd_q    <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      result_o <= '0;
    end else begin
      unique case (state_q)
        DIV_IDLE: begin
          if (accept) begin
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= a_abs;
            div_q   <= b_abs;
            dvd_q   <= opdata1_i;
            neg_q_q <= a_neg ^ b_neg;
            neg_r_q <= a_neg;
          end
        end
        DIV_DIVZERO: begin
          if (!annul_i) result_o <= {dvd_q, {WIDTH{1'b1}}};
        end
        DIV_BUSY: begin
          if (!annul_i) begin
            cnt_q <= cnt_q + CNT_W'(1);
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
            if (last) result_o <= {negate_if(neg_r_q, rem_nxt), negate_if(neg_q_q, quo_nxt)};
          end
        end
        default: ;
      endcase
    end
  end

endmodule
